// File: rtl/posit8_pkg.sv
// Shared posit8 constants, decoded-field record and the core field decoder.
// The decoder returns raw fields only; special-value flags are added by the caller.
package posit8_pkg;

  localparam logic [7:0] POSIT8_ZERO = 8'h00;
  localparam logic [7:0] POSIT8_NAR  = 8'h80;

  typedef struct packed {
    logic       s;
    logic [7:0] k;
    logic [2:0] r;
    logic [7:0] f;
    logic       zero;
    logic       nar;
  } posit8_fields_t;

  function automatic posit8_fields_t posit8_decode(input logic [7:0] p);
    posit8_fields_t d;
    logic [7:0] a;
    logic [6:0] body;
    logic [3:0] m;
    logic       run;
    a    = p[7] ? (~p + 8'd1) : p;
    body = a[6:0];
    m    = 4'd1;
    run  = 1'b1;
    // Regime run: count bits matching body[6], stopping at the first change.
    for (int i = 5; i >= 0; i--) begin
      if (run && (body[i] == body[6])) m = m + 4'd1;
      else run = 1'b0;
    end
    d.s    = p[7];
    d.k    = body[6] ? ({4'b0, m} - 8'd1) : (8'd0 - {4'b0, m});
    d.r    = (m >= 4'd6) ? 3'd7 : (m[2:0] + 3'd1);
    d.f    = {1'b0, body} << ({1'b0, d.r} + 4'd2);
    d.zero = 1'b0;
    d.nar  = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/posit8_decode_sched_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer, and moves the pointer
// just past the granted requester whenever that grant is taken.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  int            gidx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = 0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found = 1'b1;
        gidx  = (int'(ptr) + off) % NREQ;
        grant[(int'(ptr) + off) % NREQ] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (adv) ptr <= PW'((gidx + 1) % NREQ);
  end

endmodule

// File: rtl/posit8_decode_sched.sv
// Shares one posit8 field decoder between NREQ requesters: round-robin grant,
// capture stage, decode, result stage, valid/ready on both sides.
module posit8_decode_sched
  import posit8_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_s,
  output logic [7:0]        out_k,
  output logic [2:0]        out_r,
  output logic [7:0]        out_f,
  output logic              out_zero,
  output logic              out_nar
);

  logic             run_q;
  logic             s1_valid, s2_valid;
  logic [7:0]       s1_word;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  posit8_fields_t   s2_fields, dec;

  logic [NREQ-1:0]  grant;
  logic             s1_load, s2_load, xfer;
  logic [7:0]       sel_word;
  logic [TAG_W-1:0] sel_tag;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .adv   (xfer),
    .grant (grant)
  );

  always_comb begin
    sel_word = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_word = req_data[8*i +: 8];
        sel_tag  = TAG_W'(i);
      end
    end
  end

  // run_q keeps req_ready low from reset until the first edge after release.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign req_ready = grant & {NREQ{s1_load & run_q}};
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    dec      = posit8_decode(s1_word);
    dec.zero = (s1_word == POSIT8_ZERO);
    dec.nar  = (s1_word == POSIT8_NAR);
    if (dec.zero) begin
      dec.s = 1'b0;
      dec.k = 8'hF9;
      dec.r = 3'd7;
      dec.f = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      s1_valid  <= 1'b0;
      s1_word   <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_fields <= '0;
    end else begin
      run_q <= 1'b1;
      if (s1_load) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_word <= sel_word;
          s1_tag  <= sel_tag;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_fields <= dec;
          s2_tag    <= s1_tag;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_tag   = s2_tag;
  assign out_s     = s2_fields.s;
  assign out_k     = s2_fields.k;
  assign out_r     = s2_fields.r;
  assign out_f     = s2_fields.f;
  assign out_zero  = s2_fields.zero;
  assign out_nar   = s2_fields.nar;

endmodule
